issue_queue: RTL and testbench

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue_if.sv | 53 +++++
 rtl/issue_queue.sv | 147 ++++++++++++++
 tb/tb_issue_queue.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// Issue queue bus: flush, dispatch, CDB writeback and issue handshakes plus occupancy.
// master = dispatch/writeback/execute side, slave = the queue itself.
interface issue_queue_if #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned CMD       = 16
);
  localparam int unsigned TAG  = $clog2(ROB_DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic            flush;
  logic            disp_valid;
  logic            disp_ready;
  logic [TAG-1:0]  disp_tag;
  logic [CMD-1:0]  disp_cmd;
  logic [2:0]      disp_unit;
  logic            disp_src1_rdy;
  logic [TAG-1:0]  disp_src1_tag;
  logic [DATA-1:0] disp_src1_data;
  logic            disp_src2_rdy;
  logic [TAG-1:0]  disp_src2_tag;
  logic [DATA-1:0] disp_src2_data;
  logic            wb_valid;
  logic [TAG-1:0]  wb_tag;
  logic [DATA-1:0] wb_data;
  logic            iss_valid;
  logic            iss_ready;
  logic [TAG-1:0]  iss_tag;
  logic [CMD-1:0]  iss_cmd;
  logic [2:0]      iss_unit;
  logic [DATA-1:0] iss_data1;
  logic [DATA-1:0] iss_data2;
  logic [CNTW-1:0] count;

  modport master (
    output flush, disp_valid, disp_tag, disp_cmd, disp_unit,
           disp_src1_rdy, disp_src1_tag, disp_src1_data,
           disp_src2_rdy, disp_src2_tag, disp_src2_data,
           wb_valid, wb_tag, wb_data, iss_ready,
    input  disp_ready, iss_valid, iss_tag, iss_cmd, iss_unit,
           iss_data1, iss_data2, count
  );

  modport slave (
    input  flush, disp_valid, disp_tag, disp_cmd, disp_unit,
           disp_src1_rdy, disp_src1_tag, disp_src1_data,
           disp_src2_rdy, disp_src2_tag, disp_src2_data,
           wb_valid, wb_tag, wb_data, iss_ready,
    output disp_ready, iss_valid, iss_tag, iss_cmd, iss_unit,
           iss_data1, iss_data2, count
  );
endinterface

// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: entry 0 is oldest, the oldest ready entry
// issues, CDB writebacks wake pending sources (including entries being shifted
// and entries being dispatched in the same cycle).
// Optional macro ISSUE_QUEUE_WAKEUP_BYPASS_EN: an entry woken by the CDB becomes
// selectable in the same cycle with its operand forwarded from wb_data. Without
// it, selection and issue data come purely from stored state.
module issue_queue #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_DEPTH = 32,
  parameter int unsigned CMD       = 16
) (
  input logic         clk,
  input logic         reset,
  issue_queue_if.slave bus
);
  localparam int unsigned TAG  = $clog2(ROB_DEPTH);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG-1:0]  tag;
    logic [CMD-1:0]  cmd;
    logic [2:0]      unit;
    logic            r1;
    logic [TAG-1:0]  t1;
    logic [DATA-1:0] d1;
    logic            r2;
    logic [TAG-1:0]  t2;
    logic [DATA-1:0] d2;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          woke  [DEPTH];
  entry_t          new_ent;
  entry_t          sel_ent;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] wr_idx;
  logic [DEPTH-1:0] rdy;
  logic [IDXW-1:0] sel;
  logic            any_rdy;
  logic            iss_valid_c;
  logic            disp_ready_c;
  logic            iss_fire;
  logic            disp_fire;
  logic            m1, m2;

  // CDB wakeup applied to every occupied entry
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      woke[i] = ent_q[i];
      if (bus.wb_valid && (CNTW'(i) < count_q)) begin
        if (!ent_q[i].r1 && (ent_q[i].t1 == bus.wb_tag)) begin
          woke[i].r1 = 1'b1;
          woke[i].d1 = bus.wb_data;
        end
        if (!ent_q[i].r2 && (ent_q[i].t2 == bus.wb_tag)) begin
          woke[i].r2 = 1'b1;
          woke[i].d2 = bus.wb_data;
        end
      end
    end
  end

  // Oldest-ready selection
  always_comb begin
    rdy = '0;
    sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
      rdy[i] = (CNTW'(i) < count_q) && woke[i].r1 && woke[i].r2;
`else
      rdy[i] = (CNTW'(i) < count_q) && ent_q[i].r1 && ent_q[i].r2;
`endif
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (rdy[i]) sel = IDXW'(i);
    end
    any_rdy = |rdy;
  end

  assign iss_valid_c  = any_rdy && !bus.flush && !reset;
  assign disp_ready_c = reset || (count_q < CNTW'(DEPTH));
  assign iss_fire     = iss_valid_c && bus.iss_ready;
  assign disp_fire    = bus.disp_valid && disp_ready_c && !bus.flush && !reset;

  // Issue payload, zero whenever nothing is offered
  always_comb begin
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    sel_ent = woke[sel];
`else
    sel_ent = ent_q[sel];
`endif
    if (!iss_valid_c) sel_ent = '0;
  end

  assign bus.iss_valid  = iss_valid_c;
  assign bus.disp_ready = disp_ready_c;
  assign bus.iss_tag    = sel_ent.tag;
  assign bus.iss_cmd    = sel_ent.cmd;
  assign bus.iss_unit   = sel_ent.unit;
  assign bus.iss_data1  = sel_ent.d1;
  assign bus.iss_data2  = sel_ent.d2;
  assign bus.count      = count_q;

  // Incoming entry with same-cycle CDB bypass on pending sources
  always_comb begin
    m1 = !bus.disp_src1_rdy && bus.wb_valid && (bus.disp_src1_tag == bus.wb_tag);
    m2 = !bus.disp_src2_rdy && bus.wb_valid && (bus.disp_src2_tag == bus.wb_tag);
    new_ent      = '0;
    new_ent.tag  = bus.disp_tag;
    new_ent.cmd  = bus.disp_cmd;
    new_ent.unit = bus.disp_unit;
    new_ent.r1   = bus.disp_src1_rdy || m1;
    new_ent.t1   = bus.disp_src1_tag;
    new_ent.d1   = m1 ? bus.wb_data : bus.disp_src1_data;
    new_ent.r2   = bus.disp_src2_rdy || m2;
    new_ent.t2   = bus.disp_src2_tag;
    new_ent.d2   = m2 ? bus.wb_data : bus.disp_src2_data;
  end

  // Next state: compaction on issue, append on dispatch, flush clears occupancy
  always_comb begin
    wr_idx = count_q - CNTW'(iss_fire);
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      ent_d[i] = (iss_fire && (IDXW'(i) >= sel)) ? woke[i + 1] : woke[i];
    end
    ent_d[DEPTH-1] = woke[DEPTH-1];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (disp_fire && (CNTW'(i) == wr_idx)) ent_d[i] = new_ent;
    end
    count_d = count_q + CNTW'(disp_fire) - CNTW'(iss_fire);
    if (bus.flush) count_d = '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue; expectations follow the configured wakeup mode
// (ISSUE_QUEUE_WAKEUP_BYPASS_EN).
module tb_issue_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_queue_if bus ();
  issue_queue dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush          = 1'b0;
    bus.disp_valid     = 1'b0;
    bus.disp_tag       = '0;
    bus.disp_cmd       = '0;
    bus.disp_unit      = '0;
    bus.disp_src1_rdy  = 1'b0;
    bus.disp_src1_tag  = '0;
    bus.disp_src1_data = '0;
    bus.disp_src2_rdy  = 1'b0;
    bus.disp_src2_tag  = '0;
    bus.disp_src2_data = '0;
    bus.wb_valid       = 1'b0;
    bus.wb_tag         = '0;
    bus.wb_data        = '0;
  endtask

  task automatic disp(input logic [4:0] tag,
                      input logic r1, input logic [4:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [4:0] t2, input logic [31:0] d2);
    bus.disp_valid     = 1'b1;
    bus.disp_tag       = tag;
    bus.disp_cmd       = 16'hA000 | 16'(tag);
    bus.disp_unit      = tag[2:0];
    bus.disp_src1_rdy  = r1;
    bus.disp_src1_tag  = t1;
    bus.disp_src1_data = d1;
    bus.disp_src2_rdy  = r2;
    bus.disp_src2_tag  = t2;
    bus.disp_src2_data = d2;
  endtask

  task automatic wb(input logic [4:0] t, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = t;
    bus.wb_data  = d;
  endtask

  initial begin
    // reset
    idle();
    bus.iss_ready = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_iss_tag", 64'(bus.iss_tag), 64'd0);
    check("rst_iss_data1", 64'(bus.iss_data1), 64'd0);

    // basic dispatch then issue next cycle
    bus.iss_ready = 1'b1;
    disp(5'd3, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    #1;
    check("b_no_same_cycle", 64'(bus.iss_valid), 64'd0);
    step();
    idle();
    #1;
    check("b_count1", 64'(bus.count), 64'd1);
    check("b_iss_valid", 64'(bus.iss_valid), 64'd1);
    check("b_iss_tag", 64'(bus.iss_tag), 64'd3);
    check("b_iss_cmd", 64'(bus.iss_cmd), 64'hA003);
    check("b_iss_unit", 64'(bus.iss_unit), 64'd3);
    check("b_iss_data1", 64'(bus.iss_data1), 64'h11);
    check("b_iss_data2", 64'(bus.iss_data2), 64'h22);
    step();
    check("b_count0", 64'(bus.count), 64'd0);
    check("b_empty", 64'(bus.iss_valid), 64'd0);

    // wakeup two cycles after dispatch
    disp(5'd5, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h33);
    step();
    idle();
    #1;
    check("w_wait", 64'(bus.iss_valid), 64'd0);
    step();
    wb(5'd9, 32'hABCD);
    #1;
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    check("w_byp_valid", 64'(bus.iss_valid), 64'd1);
    check("w_byp_tag", 64'(bus.iss_tag), 64'd5);
    check("w_byp_data1", 64'(bus.iss_data1), 64'hABCD);
    step();
    idle();
`else
    check("w_not_yet", 64'(bus.iss_valid), 64'd0);
    step();
    idle();
    #1;
    check("w_valid", 64'(bus.iss_valid), 64'd1);
    check("w_tag", 64'(bus.iss_tag), 64'd5);
    check("w_data1", 64'(bus.iss_data1), 64'hABCD);
    check("w_data2", 64'(bus.iss_data2), 64'h33);
    step();
`endif
    check("w_count0", 64'(bus.count), 64'd0);

    // fill to capacity, refuse while full, simultaneous issue+dispatch at full
    bus.iss_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      disp(5'(10 + k), 1'b1, 5'd0, 32'(k), 1'b1, 5'd0, 32'h100 + 32'(k));
      step();
    end
    idle();
    #1;
    check("f_count8", 64'(bus.count), 64'd8);
    check("f_not_ready", 64'(bus.disp_ready), 64'd0);
    check("f_head_tag", 64'(bus.iss_tag), 64'd10);
    disp(5'd20, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0);
    step();
    #1;
    check("f_ninth_dropped", 64'(bus.count), 64'd8);
    bus.iss_ready = 1'b1;
    #1;
    check("f_full_ready", 64'(bus.disp_ready), 64'd0);
    step();
    idle();
    #1;
    check("f_count7", 64'(bus.count), 64'd7);
    check("f_ready_again", 64'(bus.disp_ready), 64'd1);
    for (int k = 1; k < 8; k++) begin
      check("f_drain_tag", 64'(bus.iss_tag), 64'(10 + k));
      step();
    end
    check("f_drained", 64'(bus.count), 64'd0);

    // issue order with a waiting older entry
    bus.iss_ready = 1'b0;
    disp(5'd1, 1'b0, 5'd30, 32'h0, 1'b1, 5'd0, 32'h1);
    step();
    disp(5'd2, 1'b1, 5'd0, 32'h2, 1'b1, 5'd0, 32'h2);
    step();
    disp(5'd3, 1'b1, 5'd0, 32'h3, 1'b1, 5'd0, 32'h3);
    step();
    idle();
    #1;
    check("o_first", 64'(bus.iss_tag), 64'd2);
    bus.iss_ready = 1'b1;
    step();
    check("o_second", 64'(bus.iss_tag), 64'd3);
    step();
    check("o_count1", 64'(bus.count), 64'd1);
    check("o_blocked", 64'(bus.iss_valid), 64'd0);
    wb(5'd30, 32'h77);
    #1;
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    check("o_byp_tag", 64'(bus.iss_tag), 64'd1);
    check("o_byp_data1", 64'(bus.iss_data1), 64'h77);
    step();
    idle();
`else
    check("o_not_yet", 64'(bus.iss_valid), 64'd0);
    step();
    idle();
    #1;
    check("o_third", 64'(bus.iss_tag), 64'd1);
    check("o_third_data1", 64'(bus.iss_data1), 64'h77);
    step();
`endif
    check("o_count0", 64'(bus.count), 64'd0);

    // wakeup of an entry that shifts down in the same cycle
    bus.iss_ready = 1'b0;
    disp(5'd4, 1'b1, 5'd0, 32'h4, 1'b1, 5'd0, 32'h4);
    step();
    disp(5'd6, 1'b0, 5'd31, 32'h0, 1'b1, 5'd0, 32'h66);
    step();
    idle();
    bus.iss_ready = 1'b1;
    wb(5'd31, 32'h99);
    #1;
    check("s_head", 64'(bus.iss_tag), 64'd4);
    step();
    idle();
    #1;
    check("s_valid", 64'(bus.iss_valid), 64'd1);
    check("s_tag", 64'(bus.iss_tag), 64'd6);
    check("s_data1", 64'(bus.iss_data1), 64'h99);
    step();
    check("s_count0", 64'(bus.count), 64'd0);

    // one broadcast wakes sources in two entries
    bus.iss_ready = 1'b0;
    disp(5'd21, 1'b1, 5'd0, 32'h1, 1'b0, 5'd12, 32'h0);
    step();
    disp(5'd22, 1'b0, 5'd12, 32'h0, 1'b1, 5'd0, 32'h2);
    step();
    idle();
    wb(5'd12, 32'hC0);
    step();
    idle();
    #1;
    check("m_tag_a", 64'(bus.iss_tag), 64'd21);
    check("m_data2_a", 64'(bus.iss_data2), 64'hC0);
    bus.iss_ready = 1'b1;
    step();
    check("m_tag_b", 64'(bus.iss_tag), 64'd22);
    check("m_data1_b", 64'(bus.iss_data1), 64'hC0);
    step();
    check("m_count0", 64'(bus.count), 64'd0);

    // flush with dispatch present
    bus.iss_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      disp(5'(k), 1'b1, 5'd0, 32'(k), 1'b1, 5'd0, 32'(k));
      step();
    end
    idle();
    #1;
    check("x_count5", 64'(bus.count), 64'd5);
    bus.flush = 1'b1;
    disp(5'd9, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9);
    bus.iss_ready = 1'b1;
    #1;
    check("x_iss_suppressed", 64'(bus.iss_valid), 64'd0);
    step();
    idle();
    #1;
    check("x_count0", 64'(bus.count), 64'd0);
    check("x_iss_valid", 64'(bus.iss_valid), 64'd0);
    step();
    check("x_nothing_written", 64'(bus.count), 64'd0);

    // dispatch-time bypass from a same-cycle writeback
    bus.iss_ready = 1'b0;
    disp(5'd8, 1'b0, 5'd7, 32'h0, 1'b1, 5'd0, 32'h66);
    wb(5'd7, 32'h55);
    step();
    idle();
    #1;
    check("d_valid", 64'(bus.iss_valid), 64'd1);
    check("d_tag", 64'(bus.iss_tag), 64'd8);
    check("d_data1", 64'(bus.iss_data1), 64'h55);
    check("d_data2", 64'(bus.iss_data2), 64'h66);
    bus.iss_ready = 1'b1;
    step();
    check("d_count0", 64'(bus.count), 64'd0);

    // reset in the middle of activity
    bus.iss_ready = 1'b0;
    disp(5'd14, 1'b1, 5'd0, 32'hE, 1'b1, 5'd0, 32'hE);
    step();
    disp(5'd15, 1'b1, 5'd0, 32'hF, 1'b1, 5'd0, 32'hF);
    step();
    reset = 1'b1;
    disp(5'd16, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h1);
    bus.iss_ready = 1'b1;
    #1;
    check("r_iss_valid", 64'(bus.iss_valid), 64'd0);
    check("r_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("r_iss_tag", 64'(bus.iss_tag), 64'd0);
    step();
    reset = 1'b0;
    idle();
    #1;
    check("r_count0", 64'(bus.count), 64'd0);
    check("r_empty", 64'(bus.iss_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
